// File: rtl/sccb_init_sequencer_pkg.sv
// Shared definitions for the SCCB init sequencer: table opcodes, entry field
// positions and FSM encodings.
package sccb_pkg;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_DELAY = 2'b01;
  localparam logic [1:0] OP_END   = 2'b10;
  localparam logic [1:0] OP_NOP   = 2'b11;

  localparam int ENT_W       = 40;
  localparam int ENT_OP_HI   = 39;
  localparam int ENT_OP_LO   = 38;
  localparam int ENT_RSVD_HI = 37;
  localparam int ENT_RSVD_LO = 36;
  localparam int ENT_WR_HI   = 35;
  localparam int ENT_WR_LO   = 32;
  localparam int ENT_DATA_HI = 31;
  localparam int ENT_DATA_LO = 0;

  localparam int DLY_W = 48;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_FETCH   = 4'd1,
    ST_DECODE  = 4'd2,
    ST_ISSUE   = 4'd3,
    ST_WAIT_HI = 4'd4,
    ST_WAIT_LO = 4'd5,
    ST_NEXT    = 4'd6,
    ST_DELAY   = 4'd7,
    ST_ERROR   = 4'd8
  } seq_state_e;

  typedef enum logic [1:0] {
    TR_IDLE = 2'd0,
    TR_HI   = 2'd1,
    TR_LO   = 2'd2
  } trk_state_e;

endpackage

// File: rtl/sccb_init_sequencer_if.sv
// Command/busy bundle between the init sequencer (master) and the SCCB core.
interface sccb_init_sequencer_if;
  logic        sccb_start;
  logic [31:0] sccb_dataout;
  logic [3:0]  sccb_wr;
  logic        sccb_busy;

  modport master (output sccb_start, output sccb_dataout, output sccb_wr, input sccb_busy);
  modport slave  (input sccb_start, input sccb_dataout, input sccb_wr, output sccb_busy);
endinterface

// File: rtl/sccb_init_sequencer_busy_tracker.sv
// Follows one start -> busy-high -> busy-low handshake; the counter restarts
// on each phase and saturating it flags a timeout.
module sccb_busy_tracker
  import sccb_pkg::*;
#(
  parameter int TO_W = 16
) (
  input  logic clk,
  input  logic rstn,
  input  logic start,
  input  logic busy,
  output logic wait_hi,
  output logic expired
);
  localparam logic [TO_W-1:0] CNT_ONE = {{(TO_W-1){1'b0}}, 1'b1};

  trk_state_e      state_r, state_s;
  logic [TO_W-1:0] cnt_r, cnt_s;

  // Handshake phase tracking; a new start always restarts the watch
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    if (start) begin
      state_s = TR_HI;
      cnt_s   = '0;
    end else begin
      case (state_r)
        TR_HI: begin
          if (busy) begin
            state_s = TR_LO;
            cnt_s   = '0;
          end else if (&cnt_r) begin
            state_s = TR_IDLE;
          end else begin
            cnt_s = cnt_r + CNT_ONE;
          end
        end
        TR_LO: begin
          if (!busy || (&cnt_r)) begin
            state_s = TR_IDLE;
          end else begin
            cnt_s = cnt_r + CNT_ONE;
          end
        end
        default: state_s = TR_IDLE;
      endcase
    end
  end

  // Phase and counter registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= TR_IDLE;
      cnt_r   <= '0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  assign wait_hi = (state_r == TR_HI);
  assign expired = (state_r != TR_IDLE) && (&cnt_r);

endmodule

// File: rtl/sccb_init_sequencer.sv
// Walks the camera-init table in an external synchronous ROM and shares the
// single SCCB master with the software command path.
module sccb_init_sequencer
  import sccb_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int DLY_SHIFT = 10,
  parameter int TO_W      = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  seq_go,
  output logic                  seq_active,
  output logic                  seq_done,
  output logic                  seq_err,
  output logic [ADDR_W-1:0]     seq_err_addr,
  output logic [ADDR_W-1:0]     rom_addr,
  output logic                  rom_en,
  input  logic [ENT_W-1:0]      rom_data,
  input  logic                  sw_start,
  input  logic [31:0]           sw_dataout,
  input  logic [3:0]            sw_wr,
  output logic                  sw_busy,
  sccb_init_sequencer_if.master sccb
);
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [DLY_W-1:0]  DLY_ONE  = {{(DLY_W-1){1'b0}}, 1'b1};

  seq_state_e        state_r, state_s;
  logic [ADDR_W-1:0] addr_r, addr_s, err_addr_r;
  logic [DLY_W-1:0]  dly_r, dly_s, dly_load_s;
  logic [31:0]       ent_data_r, pend_data_r, dout_r;
  logic [3:0]        ent_wr_r, pend_wr_r, wr_r;
  logic              seq_active_r, seq_done_r, seq_err_r, rom_en_r, start_r, pend_r;
  logic              go_s, done_set_s, err_set_s, seq_issue_s, latch_ent_s;
  logic              idle_free_s, pend_issue_s, sw_direct_s, sw_hold_s;
  logic              trk_wait_hi_s, trk_expired_s;
  logic [1:0]        unused_rsvd_s;

  assign unused_rsvd_s = rom_data[ENT_RSVD_HI:ENT_RSVD_LO];
  assign dly_load_s    = {{(DLY_W-32){1'b0}}, rom_data[ENT_DATA_HI:ENT_DATA_LO]} << DLY_SHIFT;

  // Sequencer next-state logic
  always_comb begin
    state_s     = state_r;
    addr_s      = addr_r;
    dly_s       = dly_r;
    go_s        = 1'b0;
    done_set_s  = 1'b0;
    err_set_s   = 1'b0;
    seq_issue_s = 1'b0;
    latch_ent_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (seq_go) begin
          go_s    = 1'b1;
          addr_s  = '0;
          state_s = ST_FETCH;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_FETCH: state_s = ST_DECODE;
      ST_DECODE: begin
        case (rom_data[ENT_OP_HI:ENT_OP_LO])
          OP_WRITE: begin
            latch_ent_s = 1'b1;
            state_s     = ST_ISSUE;
          end
          OP_DELAY: begin
            dly_s   = dly_load_s;
            state_s = (dly_load_s == '0) ? ST_NEXT : ST_DELAY;
          end
          OP_END: begin
            done_set_s = 1'b1;
            state_s    = ST_IDLE;
          end
          default: state_s = ST_NEXT;
        endcase
      end
      ST_ISSUE: begin
        seq_issue_s = 1'b1;
        state_s     = ST_WAIT_HI;
      end
      ST_WAIT_HI: begin
        if (sccb.sccb_busy) state_s = ST_WAIT_LO;
        else if (trk_expired_s) state_s = ST_ERROR;
        else state_s = ST_WAIT_HI;
      end
      ST_WAIT_LO: begin
        if (!sccb.sccb_busy) state_s = ST_NEXT;
        else if (trk_expired_s) state_s = ST_ERROR;
        else state_s = ST_WAIT_LO;
      end
      ST_NEXT: begin
        addr_s = addr_r + ADDR_ONE;
        if (&addr_r) begin
          done_set_s = 1'b1;
          state_s    = ST_IDLE;
        end else begin
          state_s = ST_FETCH;
        end
      end
      ST_DELAY: begin
        if (dly_r <= DLY_ONE) state_s = ST_NEXT;
        else dly_s = dly_r - DLY_ONE;
      end
      ST_ERROR: begin
        err_set_s = 1'b1;
        state_s   = ST_IDLE;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Software path: forward when the master is idle, otherwise hold as pending
  always_comb begin
    idle_free_s  = (state_r == ST_IDLE) && !seq_go && !sccb.sccb_busy && !trk_wait_hi_s;
    pend_issue_s = idle_free_s && pend_r;
    sw_direct_s  = idle_free_s && !pend_r && sw_start;
    sw_hold_s    = sw_start && !sw_direct_s;
  end

  // Sequencer state, table bookkeeping and sticky status
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r      <= ST_IDLE;
      addr_r       <= '0;
      dly_r        <= '0;
      ent_data_r   <= 32'h0;
      ent_wr_r     <= 4'h0;
      seq_active_r <= 1'b0;
      rom_en_r     <= 1'b0;
      seq_done_r   <= 1'b0;
      seq_err_r    <= 1'b0;
      err_addr_r   <= '0;
    end else begin
      state_r      <= state_s;
      addr_r       <= addr_s;
      dly_r        <= dly_s;
      seq_active_r <= (state_s != ST_IDLE);
      rom_en_r     <= (state_s == ST_FETCH);
      if (latch_ent_s) begin
        ent_data_r <= rom_data[ENT_DATA_HI:ENT_DATA_LO];
        ent_wr_r   <= rom_data[ENT_WR_HI:ENT_WR_LO];
      end
      if (go_s) begin
        seq_done_r <= 1'b0;
        seq_err_r  <= 1'b0;
      end else if (done_set_s) begin
        seq_done_r <= 1'b1;
      end else if (err_set_s) begin
        seq_err_r  <= 1'b1;
        err_addr_r <= addr_r;
      end
    end
  end

  // Pending software command and the shared SCCB command registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pend_r      <= 1'b0;
      pend_data_r <= 32'h0;
      pend_wr_r   <= 4'h0;
      start_r     <= 1'b0;
      dout_r      <= 32'h0;
      wr_r        <= 4'h0;
    end else begin
      if (sw_hold_s) begin
        pend_r      <= 1'b1;
        pend_data_r <= sw_dataout;
        pend_wr_r   <= sw_wr;
      end else if (pend_issue_s) begin
        pend_r <= 1'b0;
      end
      start_r <= seq_issue_s | pend_issue_s | sw_direct_s;
      if (seq_issue_s) begin
        dout_r <= ent_data_r;
        wr_r   <= ent_wr_r;
      end else if (pend_issue_s) begin
        dout_r <= pend_data_r;
        wr_r   <= pend_wr_r;
      end else if (sw_direct_s) begin
        dout_r <= sw_dataout;
        wr_r   <= sw_wr;
      end
    end
  end

  sccb_busy_tracker #(.TO_W(TO_W)) u_trk (
    .clk     (clk),
    .rstn    (rstn),
    .start   (seq_issue_s | pend_issue_s | sw_direct_s),
    .busy    (sccb.sccb_busy),
    .wait_hi (trk_wait_hi_s),
    .expired (trk_expired_s)
  );

  assign seq_active        = seq_active_r;
  assign seq_done          = seq_done_r;
  assign seq_err           = seq_err_r;
  assign seq_err_addr      = err_addr_r;
  assign rom_addr          = addr_r;
  assign rom_en            = rom_en_r;
  assign sw_busy           = sccb.sccb_busy | seq_active_r | pend_r | trk_wait_hi_s;
  assign sccb.sccb_start   = start_r;
  assign sccb.sccb_dataout = dout_r;
  assign sccb.sccb_wr      = wr_r;

endmodule

// File: doc/sccb_init_sequencer.md
Name: sccb_init_sequencer

Overview:
- Sequences the SCCB master through a camera-initialisation table held in an external synchronous ROM.
- Each table entry is fetched, decoded, and issued as a Start/DataOut/WR command, or executed as a delay.
- Arbitrates the single SCCB master between the sequencer and the software (APB register) command path.
- Sits between the APB register block and the SCCB core; software commands are held off while the sequencer owns the master.

Parameters:
- ADDR_W, 8, ROM address width (max 256 entries)
- DLY_SHIFT, 10, delay entry count is scaled by 2^DLY_SHIFT clk cycles
- TO_W, 16, width of the busy-handshake timeout counter; timeout = 2^TO_W-1 cycles

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- seq_go  in  1  one-cycle pulse; starts the table from address 0
- seq_active  out  1  high from go-accept until DONE or ERROR
- seq_done  out  1  sticky; set on END entry, cleared by seq_go
- seq_err  out  1  sticky; set on timeout, cleared by seq_go
- seq_err_addr  out  ADDR_W  ROM address of the entry that timed out
- rom_addr  out  ADDR_W  table address
- rom_en  out  1  read enable; data valid exactly 1 cycle later
- rom_data  in  40  entry: [39:38] op, [37:36] rsvd, [35:32] wr, [31:0] data
- sw_start  in  1  software Start pulse (from register block)
- sw_dataout  in  32  software DataOut
- sw_wr  in  4  software WR
- sw_busy  out  1  busy as seen by software
- sccb_start  out  1  Start to SCCB core (one-cycle pulse)
- sccb_dataout  out  32  DataOut to SCCB core
- sccb_wr  out  4  WR to SCCB core
- sccb_busy  in  1  Busy from SCCB core

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; pending-sw flag 0; counters 0.
- Opcodes: 00 WRITE, 01 DELAY, 10 END, 11 NOP (skip).
- FSM states and transitions:
  - IDLE: on seq_go (seq_go wins over a simultaneous sw_start): clear done/err, addr<=0, go to FETCH.
  - FETCH: rom_en=1 for one cycle, go to DECODE.
  - DECODE: act on the registered rom_data:
    - WRITE: latch wr/data, go to ISSUE.
    - DELAY: load counter with data[31:0]<<DLY_SHIFT (48-bit internal); a count of 0 goes straight to NEXT.
    - END: set seq_done, go to IDLE.
    - NOP: go to NEXT.
  - ISSUE: sccb_start=1 for exactly one cycle; clear the timeout counter; go to WAIT_HI.
  - WAIT_HI: wait for sccb_busy=1; go to ERROR on timeout.
  - WAIT_LO: wait for sccb_busy=0; go to ERROR on timeout.
  - NEXT: addr+1; if addr was all-ones (wrap), set seq_done and go to IDLE; else go to FETCH.
  - DELAY: decrement the counter each cycle; at 0 go to NEXT.
  - ERROR: set seq_err, capture seq_err_addr, go to IDLE. No retry.
- Throughput: a WRITE issues sccb_start 3 cycles after its FETCH. Minimum entry period = 5 cycles plus the SCCB transaction time.
- sccb_dataout/sccb_wr are held stable from ISSUE until sccb_busy falls, or until the next ISSUE.
- Mux ownership: the sequencer drives sccb_* while seq_active; otherwise the software path drives them.
- sw_start while seq_active or sccb_busy: latch sw_dataout/sw_wr and set the pending flag. A second sw_start while pending overwrites the latched values (last wins).
- Pending command: issued in the first IDLE cycle with sccb_busy=0, as a one-cycle sccb_start, then the pending flag clears.
- sw_start in IDLE with sccb_busy=0: forwarded combinationally-registered; sccb_start appears 1 cycle later.
- sw_busy = sccb_busy | seq_active | pending | (sccb_start issued, busy not yet seen).
- seq_go while seq_active: ignored.
- Reset mid-operation: returns to IDLE immediately, drops the pending command, drives sccb_start low. The SCCB core is reset by the same rstn.

Decomposition:
- Shared package sccb_pkg:
  - opcode constants OP_WRITE/OP_DELAY/OP_END/OP_NOP
  - entry field bit positions
  - FSM state encoding
- One natural sub-module: sccb_busy_tracker — start/busy-high/busy-low handshake with timeout, reused by both the sequencer and the software issue path.

Test Plan:
- Table {WRITE wr=4 data=0x78300811, DELAY 2, END}, SCCB model with busy high 20 cycles -> exactly one sccb_start with dataout 0x78300811/wr 4; 2048-cycle gap; seq_done=1; seq_active=0.
- SCCB model never asserts busy, TO_W=6 -> seq_err=1 after 63 cycles, seq_err_addr=0, no further sccb_start.
- sw_start (dataout 0xA5A5A5A5) mid-sequence -> sw_busy=1 throughout; software command issued once after END; sequencer entries unaffected.
- sw_start and seq_go in the same IDLE cycle -> sequencer wins; software command pending and issued after seq_done.
- rstn asserted during WAIT_LO -> all outputs 0 asynchronously; after release, seq_go restarts at rom_addr 0.
- 256 NOP entries with no END -> address wraps; seq_done=1; no sccb_start.
